// File: rtl/median_stream_ctrl_pkg.sv
// median_stream_ctrl_pkg: shared sizes and FSM state encoding for the median stream controller
//   DATA_LENGTH : sample width (unsigned)
//   WMAX        : number of systolic cells
//   LOG_WMAX    : width of W, cell numbers and the fill counter
package median_stream_ctrl_pkg;
  localparam int DATA_LENGTH = 32;
  localparam int WMAX = 16;
  localparam int LOG_WMAX = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, STREAM = 2'd2} state_t;
endpackage

// File: rtl/median_stream_ctrl_median_select.sv
// median_select: picks the median from the sorted cell registers for window size w
//   cell_data : R1 of cells 1..WMAX, cell 1 (largest) in the LSBs
//   w         : latched window size
//   median    : middle cell for odd w, floored mean of the two middle cells for even w
module median_select #(
  parameter int DATA_LENGTH = median_stream_ctrl_pkg::DATA_LENGTH,
  parameter int WMAX = median_stream_ctrl_pkg::WMAX,
  parameter int LOG_WMAX = median_stream_ctrl_pkg::LOG_WMAX
) (
  input  logic [WMAX*DATA_LENGTH-1:0] cell_data,
  input  logic [LOG_WMAX-1:0]         w,
  output logic [DATA_LENGTH-1:0]      median
);
  logic [DATA_LENGTH-1:0] cells [WMAX];
  logic [LOG_WMAX-1:0] lo_idx, hi_idx;
  logic [DATA_LENGTH:0] sum;
  for (genvar i = 0; i < WMAX; i++) begin : g_cell
    assign cells[i] = cell_data[i*DATA_LENGTH +: DATA_LENGTH];
  end
  // cells[] is 0-based: cell (w+1)/2 is index w>>1 for odd w; for even w the
  // pair w/2, w/2+1 sits at indices w/2-1 and w/2
  always_comb begin
    lo_idx = w >> 1;
    hi_idx = lo_idx - 1'b1;
    sum = {1'b0, cells[lo_idx]} + {1'b0, cells[hi_idx]};
    median = w[0] ? cells[lo_idx] : sum[DATA_LENGTH:1];
  end
endmodule

// File: rtl/median_stream_ctrl.sv
// median_stream_ctrl: stream front/back end for the systolic median array
//   clk, reset          : clock, synchronous active-high reset
//   W, flush            : requested window size (taken in IDLE), clear/restart request
//   in_valid/in_ready/in_data    : sample input handshake
//   arr_x/arr_en/arr_clear/arr_w : array X bus, clock enable, clear, latched window size
//   cell_data           : sorted cell registers read back from the array
//   out_valid/out_ready/out_data : median output handshake
//   fill_cnt, cfg_err   : samples in window (saturating), latched W was zero
module median_stream_ctrl #(
  parameter int DATA_LENGTH = median_stream_ctrl_pkg::DATA_LENGTH,
  parameter int WMAX = median_stream_ctrl_pkg::WMAX,
  parameter int LOG_WMAX = median_stream_ctrl_pkg::LOG_WMAX
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [LOG_WMAX-1:0]         W,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [DATA_LENGTH-1:0]      in_data,
  output logic                        in_ready,
  output logic [DATA_LENGTH-1:0]      arr_x,
  output logic                        arr_en,
  output logic                        arr_clear,
  output logic [LOG_WMAX-1:0]         arr_w,
  input  logic [WMAX*DATA_LENGTH-1:0] cell_data,
  output logic                        out_valid,
  output logic [DATA_LENGTH-1:0]      out_data,
  input  logic                        out_ready,
  output logic [LOG_WMAX-1:0]         fill_cnt,
  output logic                        cfg_err
);
  import median_stream_ctrl_pkg::*;
  state_t state, state_nxt;
  logic sample, fill_done;
  logic [LOG_WMAX-1:0] fill_inc;
  // a zero W parks IDLE (cfg_err) until flush/reset, so W is only re-sampled then
  assign sample = state == IDLE && !cfg_err;
  assign fill_inc = fill_cnt + 1'b1;
  assign fill_done = state == FILL && arr_en && fill_inc == arr_w;
  always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = flush ? IDLE : sample ? (W == '0 ? IDLE : FILL) : fill_done ? STREAM : state;
  end
  // the array only moves on accepts, so blocking accepts while a median waits
  // keeps out_data stable under backpressure
  always_comb begin
    in_ready = !reset && !flush && (state == FILL || (state == STREAM && (!out_valid || out_ready)));
    arr_en = in_valid && in_ready;
    arr_clear = state == IDLE;
    arr_x = in_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt <= '0;
      out_valid <= 1'b0;
      cfg_err <= 1'b0;
      arr_w <= '0;
    end else if (flush) begin
      fill_cnt <= '0;
      out_valid <= 1'b0;
      cfg_err <= 1'b0;
    end else if (sample) begin
      fill_cnt <= '0;
      out_valid <= 1'b0;
      cfg_err <= W == '0;
      arr_w <= W;
    end else begin
      if (arr_en && state == FILL) fill_cnt <= fill_inc;
      // in STREAM every accept already evicted the oldest sample, so it yields a fresh median
      out_valid <= fill_done || (state == STREAM && (arr_en || (out_valid && !out_ready)));
    end
  end
  median_select #(
    .DATA_LENGTH(DATA_LENGTH),
    .WMAX(WMAX),
    .LOG_WMAX(LOG_WMAX)
  ) u_select (
    .cell_data(cell_data),
    .w(arr_w),
    .median(out_data)
  );
endmodule

// File: tb/tb_median_stream_ctrl.sv
// tb_median_stream_ctrl: randomized scoreboard bench for median_stream_ctrl with a behavioural array
module tb_median_stream_ctrl;
  localparam int DL = 32;
  localparam int WM = 16;
  localparam int LW = 4;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [LW-1:0] W = 3;
  logic [DL-1:0] in_data = '0;
  logic in_ready, arr_en, arr_clear, out_valid, cfg_err;
  logic [DL-1:0] arr_x, out_data;
  logic [LW-1:0] arr_w, fill_cnt;
  logic [WM*DL-1:0] cell_data = '0;
  int checks = 0, failures = 0;
  logic fixed_rdy = 1, rnd_rdy = 0;
  logic [DL-1:0] exp_q[$];
  logic [DL-1:0] hist[$];
  int ref_w = 3;

  always #5 clk = ~clk;

  median_stream_ctrl dut (
    .clk(clk), .reset(reset), .W(W), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .arr_x(arr_x), .arr_en(arr_en), .arr_clear(arr_clear), .arr_w(arr_w),
    .cell_data(cell_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fill_cnt(fill_cnt), .cfg_err(cfg_err)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  function automatic logic [DL-1:0] ref_median(input logic [DL-1:0] win[$]);
    logic [DL-1:0] s[$];
    logic [DL:0] t;
    int n;
    s = win;
    s.sort();
    n = s.size();
    if (n % 2 == 1) return s[n/2];
    t = {1'b0, s[n/2-1]} + {1'b0, s[n/2]};
    return t[DL:1];
  endfunction

  // behavioural systolic array: sliding window of the last arr_w accepts, sorted descending
  logic cap_en = 0, cap_clr = 1;
  logic [DL-1:0] cap_x;
  logic [LW-1:0] cap_w;
  logic [DL-1:0] win[$];
  logic [DL-1:0] sorted[$];
  logic [WM*DL-1:0] nxt;
  always @(negedge clk) begin
    cap_en = arr_en; cap_clr = arr_clear; cap_x = arr_x; cap_w = arr_w;
  end
  always @(posedge clk) begin
    if (cap_clr) win.delete();
    else if (cap_en) begin
      win.push_back(cap_x);
      if (win.size() > int'(cap_w)) void'(win.pop_front());
    end
    sorted = win;
    sorted.rsort();
    for (int i = 0; i < WM; i++) nxt[i*DL +: DL] = i < sorted.size() ? sorted[i] : '0;
    cell_data <= nxt;
  end

  always @(posedge clk) begin
    #2;
    out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
  end

  // monitor: pops the scoreboard on every output handshake
  logic prev_stall = 0;
  logic [DL-1:0] prev_data;
  always @(negedge clk) begin
    chk("arr_en_vs_accept", arr_en, in_valid && in_ready);
    chk("arr_x", arr_x, in_data);
    chk("fill_le_w", fill_cnt <= arr_w, 1);
    if (prev_stall) chk("hold_data", out_data, prev_data);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("out_data", out_data, exp_q.pop_front());
    end
    if (flush || reset) exp_q.delete();
    prev_stall = out_valid && !out_ready && !flush && !reset;
    prev_data = out_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DL-1:0] d);
    bit done = 0;
    in_valid = 1;
    in_data = d;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        hist.push_back(d);
        if (hist.size() > ref_w) void'(hist.pop_front());
        if (hist.size() == ref_w) exp_q.push_back(ref_median(hist));
      end
      tick();
    end
    in_valid = 0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic restart(input int w);
    W = LW'(w);
    flush = 1;
    tick();
    flush = 0;
    hist.delete();
    ref_w = w;
  endtask

  task automatic drain();
    rnd_rdy = 0;
    fixed_rdy = 1;
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DL-1:0] held;
    // reset state
    W = 3; reset = 1;
    tick(); tick();
    @(negedge clk);
    chk("rst_fill", fill_cnt, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_cfg", cfg_err, 0);
    chk("rst_arr_w", arr_w, 0);
    chk("rst_clear", arr_clear, 1);
    chk("rst_ready", in_ready, 0);
    tick();
    reset = 0; hist.delete(); ref_w = 3;
    // W=3: 5,1,9,7 -> 5 then 7
    fixed_rdy = 1;
    send(5); send(1);
    @(negedge clk);
    chk("w3_not_yet", out_valid, 0);
    chk("w3_fill2", fill_cnt, 2);
    tick();
    send(9);
    @(negedge clk);
    chk("w3_latency", out_valid, 1);
    chk("w3_fill3", fill_cnt, 3);
    chk("w3_med5", out_data, 5);
    tick();
    send(7);
    @(negedge clk);
    chk("w3_fill_sat", fill_cnt, 3);
    chk("w3_med7", out_data, 7);
    tick();
    drain();
    // W=4 even averages, including the overflow corner
    restart(4);
    send(10); send(3); send(8); send(6);
    @(negedge clk);
    chk("w4_avg", out_data, 7);
    tick();
    send(32'hFFFFFFFF); send(32'hFFFFFFFF); send(32'hFFFFFFFD); send(0);
    @(negedge clk);
    chk("w4_no_ovf", out_data, 32'hFFFFFFFE);
    tick();
    drain();
    // backpressure for 5 cycles
    restart(3);
    send($urandom); send($urandom); send($urandom);
    fixed_rdy = 0;
    in_valid = 1; in_data = 32'h1234;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) held = out_data;
      chk("bp_ready", in_ready, 0);
      chk("bp_en", arr_en, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, held);
      tick();
    end
    fixed_rdy = 1;
    send(32'h1234);
    for (int k = 0; k < 6; k++) send($urandom_range(0, 50));
    drain();
    // flush mid-FILL with in_valid high, W 3 -> 5
    restart(3);
    send($urandom); send($urandom);
    W = 5; in_valid = 1; in_data = 32'hDEAD; flush = 1;
    @(negedge clk);
    chk("flush_ready", in_ready, 0);
    chk("flush_en", arr_en, 0);
    tick();
    flush = 0; in_valid = 0; hist.delete(); ref_w = 5;
    @(negedge clk);
    chk("flush_clear", arr_clear, 1);
    chk("flush_fill", fill_cnt, 0);
    chk("flush_valid", out_valid, 0);
    tick();
    @(negedge clk);
    chk("flush_arr_w", arr_w, 5);
    chk("flush_fill_state", arr_clear, 0);
    tick();
    for (int k = 0; k < 4; k++) send($urandom_range(0, 1000));
    @(negedge clk);
    chk("w5_not_yet", out_valid, 0);
    chk("w5_fill4", fill_cnt, 4);
    tick();
    send($urandom_range(0, 1000));
    @(negedge clk);
    chk("w5_valid", out_valid, 1);
    tick();
    drain();
    // randomized rounds, restarts may drop pending medians
    rnd_rdy = 1;
    for (int r = 0; r < 6; r++) begin
      restart($urandom_range(1, 15));
      for (int k = 0; k < 40; k++) send(k % 2 ? $urandom : $urandom_range(0, 7));
    end
    drain();
    // W=0 parks with cfg_err until flush
    W = 0; reset = 1;
    tick();
    reset = 0;
    tick(); tick();
    in_valid = 1; in_data = 32'h55;
    W = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("w0_cfg", cfg_err, 1);
      chk("w0_ready", in_ready, 0);
      chk("w0_arr_w", arr_w, 0);
      tick();
    end
    in_valid = 0;
    restart(1);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("w1_arr_w", arr_w, 1);
    chk("w1_cfg", cfg_err, 0);
    tick();
    rnd_rdy = 1;
    for (int k = 0; k < 20; k++) send($urandom);
    drain();
    // reset during STREAM with a pending median
    restart(3);
    send(11); send(22); send(33);
    fixed_rdy = 0;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    tick();
    reset = 1;
    tick();
    reset = 0; hist.delete(); ref_w = 3;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_fill", fill_cnt, 0);
    chk("mid_rst_clear", arr_clear, 1);
    chk("mid_rst_arr_w", arr_w, 0);
    tick();
    fixed_rdy = 1;
    for (int k = 0; k < 5; k++) send($urandom_range(0, 99));
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
